nios2_qsys_cpu_ocimem_ctrl: RTL and testbench
=============================================

# nios2_qsys_cpu_ocimem_ctrl

On-chip debug memory controller for the Nios II JTAG debug module, clocked in the system-clock domain. It consumes the `jdo` shift-register snapshot and the `take_*_ocimem_*` strobes from the debug module's system-clock half. It executes JTAG reads and writes against a shared debug RAM and returns read data on `MonDReg` for capture into the JTAG shift chain. The CPU reaches the same RAM through an Avalon-MM slave port; JTAG always has priority.

## Interface
- `ADDR_W`, default 8: word-address width; the RAM holds 2^ADDR_W 32-bit words.
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `jdo` in 38: JTAG data snapshot.
  - `jdo[34:3]` is write data.
  - `jdo[34]` is the read-now flag on an address load.
  - `jdo[ADDR_W+16:17]` is the word address.
- `take_action_ocimem_a` in 1: one-cycle strobe; load address, optionally read.
- `take_no_action_ocimem_a` in 1: one-cycle strobe; increment address, then read.
- `take_action_ocimem_b` in 1: one-cycle strobe; write data, then increment address.
- `cpu_address` in ADDR_W: Avalon word address.
- `cpu_read`, `cpu_write` in 1: Avalon requests.
- `cpu_writedata` in 32: Avalon write data.
- `cpu_byteenable` in 4: Avalon byte enables.
- `cpu_readdata` out 32: Avalon read data.
- `cpu_waitrequest` out 1: Avalon stall.
- `MonDReg` out 32: last JTAG read data, routed to the debug module.
- `mon_rd_valid` out 1: one-cycle pulse when `MonDReg` updates.
- `MonAReg` out ADDR_W: current JTAG word address.
- `jtag_overrun` out 1: sticky; a JTAG strobe was dropped.

## Operation
- States:
  - `IDLE`
  - `JRD`: RAM addressed for a JTAG read.
  - `JCAP`: capture RAM output.
  - `JWR`: RAM written for JTAG.
  - `CRD`: CPU read data returning.
- From `IDLE`, strobes take priority in the order `take_action_ocimem_b` > `take_action_ocimem_a` > `take_no_action_ocimem_a` > CPU request.
- `take_action_ocimem_a`:
  - `MonAReg` <= address field.
  - If `jdo[34]`=1, go to `JRD`; otherwise stay in `IDLE`.
- `take_no_action_ocimem_a`: `MonAReg` <= `MonAReg`+1, then go to `JRD`.
- `take_action_ocimem_b`: latch `jdo[34:3]` and go to `JWR`.
  - In `JWR`, write all 4 bytes at `MonAReg`.
  - Leaving `JWR`: `MonAReg`+1, go to `IDLE`.
- `JRD` -> `JCAP` -> `IDLE`.
  - On the `JCAP` exit edge: `MonDReg` <= RAM data and `mon_rd_valid`=1 for one cycle.
- CPU write in `IDLE` with no strobe pending: write is performed that cycle with byte enables; `cpu_waitrequest`=0; stay in `IDLE`.
- CPU read in `IDLE` with no strobe pending: RAM is addressed, go to `CRD`.
  - In `CRD`: `cpu_readdata` = RAM data, `cpu_waitrequest`=0, then return to `IDLE`.
- `cpu_waitrequest`:
  - =1 whenever `cpu_read|cpu_write` and the request is not granted this cycle.
  - =1 on the grant cycle of a read.
  - =0 when there is no request.
- A strobe arriving in any non-`IDLE` state is dropped and sets `jtag_overrun`. Only `reset` clears `jtag_overrun`.
- `MonAReg` arithmetic is modulo 2^ADDR_W: the maximum address increments to 0.
- Simultaneous `cpu_read` and `cpu_write`: treated as a write.

## Timing
- Reset values:
  - state `IDLE`
  - `MonAReg`=0, `MonDReg`=0
  - `mon_rd_valid`=0, `jtag_overrun`=0
  - `cpu_readdata`=0
  - `cpu_waitrequest`=1 if a request is present, else 0
- RAM contents are not cleared by reset.
- Reset mid-operation aborts the operation. A `JWR` already at its write edge completes that write.
- RAM has a one-cycle registered read.
- JTAG read: a strobe at edge N gives `mon_rd_valid` high in cycle N+3 with `MonDReg` valid from that edge.
- JTAG write: a strobe at edge N writes RAM at edge N+2; `MonAReg` is incremented after edge N+2.
- CPU read: granted in cycle A; `cpu_waitrequest`=0 and data valid in cycle A+1.
- CPU write: zero wait states when granted.
- Upstream guarantees at least 4 cycles between JTAG strobes. The overrun flag exists for verification, not correctness.

## Structure
- Package `nios2_qsys_cpu_ocimem_pkg` holds:
  - the state enum;
  - the `jdo` field bit positions: `JDO_WDATA_HI`=34, `JDO_WDATA_LO`=3, `JDO_RDFLAG`=34, `JDO_ADDR_LO`=17.
- Sub-module `nios2_qsys_cpu_ocimem_ram`: single-port, ADDR_W x 32, per-byte write enables, registered read.
- The controller owns muxing, arbitration and address/data registers.

## Test plan
- Address load with read:
  - RAM[0x10]=0xDEADBEEF; `take_action_ocimem_a` with address 0x10 and `jdo[34]`=1.
  - Required: `MonDReg`=0xDEADBEEF with `mon_rd_valid` 3 cycles after the strobe; `MonAReg`=0x10.
- Streaming write then read-back:
  - Load address 0xFE (no read), then three `take_action_ocimem_b` writes of 0x1, 0x2, 0x3.
  - Required: RAM[0xFE]=1, RAM[0xFF]=2, RAM[0x00]=3 (wrap-around); `MonAReg`=0x01.
- Collision:
  - `cpu_write` to 0x20 in the same cycle as `take_action_ocimem_b`.
  - Required: JTAG write first; CPU held (`cpu_waitrequest`=1) until `IDLE`; both writes land.
- CPU byte-enable and read latency:
  - Write 0xAABBCCDD with `cpu_byteenable`=4'b0101 over 0.
  - Required: word reads 0x00BB00DD; read shows exactly one wait cycle.
- Overrun:
  - `take_no_action_ocimem_a` issued during `JCAP`.
  - Required: strobe dropped; `jtag_overrun`=1; `MonAReg` unchanged.
- Reset mid-read:
  - `reset` asserted in `JRD`.
  - Required: next cycle in `IDLE`, `MonDReg`=0, no `mon_rd_valid` pulse, RAM unchanged.

Source files
------------

// File: rtl/nios2_qsys_cpu_ocimem_pkg.sv
// Shared types and jdo field positions for the Nios II on-chip debug memory controller.
package nios2_qsys_cpu_ocimem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_JRD  = 3'd1,
    ST_JCAP = 3'd2,
    ST_JWR  = 3'd3,
    ST_CRD  = 3'd4
  } ocimem_state_e;

  localparam int JDO_WDATA_HI = 32'd34;
  localparam int JDO_WDATA_LO = 32'd3;
  localparam int JDO_RDFLAG   = 32'd34;
  localparam int JDO_ADDR_LO  = 32'd17;

endpackage

// File: rtl/nios2_qsys_cpu_ocimem.sv
// The on-chip debug memory controller top level is nios2_qsys_cpu_ocimem_ctrl, defined in nios2_qsys_cpu_ocimem_ctrl.sv.

// File: rtl/nios2_qsys_cpu_ocimem_ram.sv
// Single-port debug RAM: 32-bit words, per-byte write enables, one-cycle registered read.
module nios2_qsys_cpu_ocimem_ram
  import nios2_qsys_cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 32'd1 << ADDR_W;

  logic [31:0] mem_q [0:DEPTH-1];
  logic [31:0] rdata_q;

  // Byte-masked write and read-old-data registered read; contents deliberately have no reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) begin
        mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/nios2_qsys_cpu_ocimem_ctrl.sv
// JTAG/Avalon arbitration for the shared debug RAM; JTAG strobes always win over CPU requests.
module nios2_qsys_cpu_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              mon_rd_valid,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              jtag_overrun
);
  import nios2_qsys_cpu_ocimem_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  ocimem_state_e     state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overrun_q, overrun_d;

  logic              strobe_s, idle_free_s, cpu_wr_grant_s, cpu_rd_grant_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic              ram_we_s;
  logic [3:0]        ram_be_s;
  logic [31:0]       ram_wdata_s, ram_rdata_s;
  logic              jdo_unused_s;

  assign strobe_s       = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign idle_free_s    = (state_q == ST_IDLE) && !strobe_s && !reset;
  assign cpu_wr_grant_s = idle_free_s && cpu_write;
  assign cpu_rd_grant_s = idle_free_s && cpu_read && !cpu_write;
  assign jdo_unused_s   = ^{jdo[37:35], jdo[2:0]};

  // RAM port mux; a JWR write is not gated by reset so it completes at its edge.
  always_comb begin
    ram_addr_s  = mon_a_q;
    ram_we_s    = 1'b0;
    ram_be_s    = 4'h0;
    ram_wdata_s = wdata_q;
    if (state_q == ST_JWR) begin
      ram_we_s = 1'b1;
      ram_be_s = 4'hF;
    end else if (cpu_wr_grant_s) begin
      ram_addr_s  = cpu_address;
      ram_we_s    = 1'b1;
      ram_be_s    = cpu_byteenable;
      ram_wdata_s = cpu_writedata;
    end else if (cpu_rd_grant_s) begin
      ram_addr_s = cpu_address;
    end else begin
      ram_addr_s = mon_a_q;
    end
  end

  // Next-state and register-update logic for the controller FSM.
  always_comb begin
    state_d    = state_q;
    mon_a_d    = mon_a_q;
    mon_d_d    = mon_d_q;
    wdata_d    = wdata_q;
    rd_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (take_action_ocimem_b) begin
          wdata_d = jdo[JDO_WDATA_HI:JDO_WDATA_LO];
          state_d = ST_JWR;
        end else if (take_action_ocimem_a) begin
          mon_a_d = jdo[JDO_ADDR_LO +: ADDR_W];
          state_d = jdo[JDO_RDFLAG] ? ST_JRD : ST_IDLE;
        end else if (take_no_action_ocimem_a) begin
          mon_a_d = mon_a_q + ADDR_ONE;
          state_d = ST_JRD;
        end else if (cpu_rd_grant_s) begin
          state_d = ST_CRD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_JRD:  state_d = ST_JCAP;
      ST_JCAP: begin
        mon_d_d    = ram_rdata_s;
        rd_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_JWR: begin
        mon_a_d = mon_a_q + ADDR_ONE;
        state_d = ST_IDLE;
      end
      ST_CRD:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (strobe_s && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mon_a_q    <= {ADDR_W{1'b0}};
      mon_d_q    <= 32'h0;
      wdata_q    <= 32'h0;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mon_a_q    <= mon_a_d;
      mon_d_q    <= mon_d_d;
      wdata_q    <= wdata_d;
      rd_valid_q <= rd_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  nios2_qsys_cpu_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr_s),
    .we    (ram_we_s),
    .be    (ram_be_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  assign MonAReg         = mon_a_q;
  assign MonDReg         = mon_d_q;
  assign mon_rd_valid    = rd_valid_q;
  assign jtag_overrun    = overrun_q;
  assign cpu_readdata    = (state_q == ST_CRD) ? ram_rdata_s : 32'h0;
  assign cpu_waitrequest = (cpu_read | cpu_write) &&
                           !(cpu_wr_grant_s || ((state_q == ST_CRD) && !reset));

endmodule

// File: tb/tb_nios2_qsys_cpu_ocimem_ctrl.sv
// Directed plus randomized bench checking the debug memory controller against a word-array model.
module tb_nios2_qsys_cpu_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [7:0]  cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [31:0] MonDReg;
  logic        mon_rd_valid;
  logic [7:0]  MonAReg;
  logic        jtag_overrun;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [0:255];
  logic [7:0]  mon_a_m;
  logic [31:0] mon_d_m;

  nios2_qsys_cpu_ocimem_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
    .MonDReg(MonDReg), .mon_rd_valid(mon_rd_valid), .MonAReg(MonAReg),
    .jtag_overrun(jtag_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] jdo_load(input logic [7:0] a, input logic rd);
    logic [37:0] j;
    j = {6'($urandom), $urandom};
    j[24:17] = a;
    j[34] = rd;
    return j;
  endfunction

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    cpu_address = a; cpu_writedata = d; cpu_byteenable = be; cpu_write = 1'b1;
    #1;
    check("cpu_wr_wait", 32'(cpu_waitrequest), 32'd0);
    tick();
    cpu_write = 1'b0;
    for (int b = 0; b < 4; b++) if (be[b]) mem_m[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic cpu_rd(input logic [7:0] a, output logic [31:0] d, output int waits);
    cpu_address = a; cpu_read = 1'b1; waits = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (cpu_waitrequest === 1'b0) break;
      waits++;
      tick();
    end
    d = cpu_readdata;
    tick();
    cpu_read = 1'b0;
  endtask

  task automatic cpu_rd_check(input logic [7:0] a);
    logic [31:0] d;
    int w;
    cpu_rd(a, d, w);
    check("cpu_rd_waits", 32'(w), 32'd1);
    check("cpu_rd_data", d, mem_m[a]);
  endtask

  // strobe already driven; expect valid pulse exactly 3 edges after strobe is raised
  task automatic jtag_wait_read();
    int lat;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0;
      if (mon_rd_valid === 1'b1) begin lat = i; break; end
    end
    mon_d_m = mem_m[mon_a_m];
    check("jrd_latency", 32'(lat), 32'd3);
    check("jrd_mondreg", MonDReg, mon_d_m);
    check("jrd_monareg", 32'(MonAReg), 32'(mon_a_m));
    tick();
    check("jrd_pulse_end", 32'(mon_rd_valid), 32'd0);
  endtask

  task automatic jtag_load_read(input logic [7:0] a);
    jdo = jdo_load(a, 1'b1); take_action_ocimem_a = 1'b1;
    mon_a_m = a;
    jtag_wait_read();
  endtask

  task automatic jtag_next_read();
    take_no_action_ocimem_a = 1'b1;
    mon_a_m = mon_a_m + 8'd1;
    jtag_wait_read();
  endtask

  task automatic jtag_load_noread(input logic [7:0] a);
    jdo = jdo_load(a, 1'b0); take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    mon_a_m = a;
    check("jld_monareg", 32'(MonAReg), 32'(a));
    tick();
    check("jld_novalid", 32'(mon_rd_valid), 32'd0);
  endtask

  task automatic jtag_write(input logic [31:0] d);
    jdo = {6'($urandom), $urandom};
    jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    check("jwr_addr_hold", 32'(MonAReg), 32'(mon_a_m));
    tick();
    mem_m[mon_a_m] = d;
    mon_a_m = mon_a_m + 8'd1;
    check("jwr_addr_inc", 32'(MonAReg), 32'(mon_a_m));
  endtask

  initial begin
    logic [31:0] rd_d;
    int          rd_w;
    logic [7:0]  old_a;
    reset = 1'b1; jdo = 38'h0;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    cpu_address = 8'h0; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_writedata = 32'h0; cpu_byteenable = 4'h0;
    mon_a_m = 8'h0; mon_d_m = 32'h0;

    tick(); tick();
    check("rst_monareg", 32'(MonAReg), 32'd0);
    check("rst_mondreg", MonDReg, 32'd0);
    check("rst_valid", 32'(mon_rd_valid), 32'd0);
    check("rst_overrun", 32'(jtag_overrun), 32'd0);
    check("rst_readdata", cpu_readdata, 32'd0);
    check("rst_wait_idle", 32'(cpu_waitrequest), 32'd0);
    cpu_read = 1'b1;
    #1;
    check("rst_wait_req", 32'(cpu_waitrequest), 32'd1);
    cpu_read = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 256; i++) cpu_wr(8'(i), $urandom, 4'hF);

    // address load with read
    cpu_wr(8'h10, 32'hDEADBEEF, 4'hF);
    jtag_load_read(8'h10);
    check("tp1_mondreg", MonDReg, 32'hDEADBEEF);

    // streaming write with wrap
    jtag_load_noread(8'hFE);
    jtag_write(32'h1); jtag_write(32'h2); jtag_write(32'h3);
    check("tp2_monareg", 32'(MonAReg), 32'h01);
    cpu_rd(8'hFE, rd_d, rd_w); check("tp2_ram_fe", rd_d, 32'h1);
    cpu_rd(8'hFF, rd_d, rd_w); check("tp2_ram_ff", rd_d, 32'h2);
    cpu_rd(8'h00, rd_d, rd_w); check("tp2_ram_00", rd_d, 32'h3);

    // collision: JTAG write wins, CPU write held then lands
    old_a = mon_a_m;
    jdo = 38'h0; jdo[34:3] = 32'h5A5A1234; take_action_ocimem_b = 1'b1;
    cpu_address = 8'h20; cpu_writedata = 32'hC0FFEE01; cpu_byteenable = 4'hF; cpu_write = 1'b1;
    #1; check("col_wait0", 32'(cpu_waitrequest), 32'd1);
    tick(); take_action_ocimem_b = 1'b0;
    #1; check("col_wait1", 32'(cpu_waitrequest), 32'd1);
    tick();
    #1; check("col_wait2", 32'(cpu_waitrequest), 32'd0);
    tick(); cpu_write = 1'b0;
    mem_m[old_a] = 32'h5A5A1234; mem_m[8'h20] = 32'hC0FFEE01;
    mon_a_m = old_a + 8'd1;
    check("col_monareg", 32'(MonAReg), 32'(mon_a_m));
    cpu_rd_check(old_a);
    cpu_rd_check(8'h20);

    // byte enables and read latency
    cpu_wr(8'h00, 32'h0, 4'hF);
    cpu_wr(8'h00, 32'hAABBCCDD, 4'b0101);
    cpu_rd(8'h00, rd_d, rd_w);
    check("be_data", rd_d, 32'h00BB00DD);
    check("be_waits", 32'(rd_w), 32'd1);

    // overrun: strobe during JCAP is dropped
    check("ovr_before", 32'(jtag_overrun), 32'd0);
    jdo = jdo_load(8'h33, 1'b1); take_action_ocimem_a = 1'b1;
    tick(); take_action_ocimem_a = 1'b0;
    tick();
    take_no_action_ocimem_a = 1'b1;
    tick(); take_no_action_ocimem_a = 1'b0;
    mon_a_m = 8'h33; mon_d_m = mem_m[8'h33];
    check("ovr_valid", 32'(mon_rd_valid), 32'd1);
    check("ovr_mondreg", MonDReg, mon_d_m);
    check("ovr_flag", 32'(jtag_overrun), 32'd1);
    tick();
    check("ovr_monareg", 32'(MonAReg), 32'h33);
    check("ovr_novalid", 32'(mon_rd_valid), 32'd0);
    check("ovr_sticky", 32'(jtag_overrun), 32'd1);

    // reset in JRD aborts the read
    jdo = jdo_load(8'h44, 1'b1); take_action_ocimem_a = 1'b1;
    tick(); take_action_ocimem_a = 1'b0;
    reset = 1'b1;
    tick(); reset = 1'b0;
    mon_a_m = 8'h0; mon_d_m = 32'h0;
    check("rsr_mondreg", MonDReg, 32'd0);
    check("rsr_monareg", 32'(MonAReg), 32'd0);
    check("rsr_overrun", 32'(jtag_overrun), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("rsr_novalid", 32'(mon_rd_valid), 32'd0);
      tick();
    end
    cpu_rd_check(8'h44);

    // randomized mix against the model
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(5, 0))
        0: cpu_wr(8'($urandom), $urandom, 4'($urandom));
        1: cpu_rd_check(8'($urandom));
        2: jtag_load_read(8'($urandom));
        3: jtag_next_read();
        4: jtag_write($urandom);
        default: jtag_load_noread(8'($urandom));
      endcase
    end
    check("final_overrun", 32'(jtag_overrun), 32'd0);
    check("final_monareg", 32'(MonAReg), 32'(mon_a_m));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
